// File: rtl/esdi_cmd_sequencer.sv
// Purpose: answers ESDI status/config requests from word tables, forwards other commands to software.
// Latency: hardware answer releases 3 cycles after the command is seen; software path releases 1 cycle after the reply.
// Backpressure: holds sw_cmd_valid until sw_cmd_ready; abandons a forwarded command after SW_TIMEOUT cycles.
module esdi_cmd_sequencer #(
  parameter int unsigned SW_TIMEOUT = 1_000_000
) (
  input  logic        csr_aclk,
  input  logic        csr_aresetn,
  input  logic        hw_enable,
  input  logic        eng_cmd_valid,
  input  logic [16:0] eng_cmd_data,
  output logic        eng_resp_valid,
  output logic [15:0] eng_resp_data,
  output logic        eng_release,
  input  logic        tbl_we,
  input  logic [4:0]  tbl_addr,
  input  logic [15:0] tbl_wdata,
  output logic        sw_cmd_valid,
  output logic [16:0] sw_cmd_data,
  input  logic        sw_cmd_ready,
  input  logic        sw_resp_valid,
  input  logic        sw_resp_has_data,
  input  logic [15:0] sw_resp_data,
  output logic        sw_resp_ready,
  output logic        attention_req,
  output logic [15:0] hw_count,
  output logic [15:0] sw_count,
  output logic [15:0] perr_count,
  output logic [15:0] tmo_count
);

  localparam int TW = $clog2(SW_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_HW_RESP, S_SW_FWD, S_SW_RESP, S_RELEASE, S_DRAIN
  } state_t;

  state_t      state, next_state;
  logic [16:0] cmd_q;
  logic [TW-1:0] tmo_cnt;
  logic        resp_flag;
  logic [15:0] tbl [32];

  logic [3:0]  opcode;
  logic        hw_hit, timed_out;
  logic [4:0]  tbl_idx;
  logic        do_latch, do_perr, do_hw, do_sw, do_tmo, do_cap, clr_tmo;

  assign opcode    = cmd_q[15:12];
  assign hw_hit    = hw_enable && (opcode == 4'd2 || opcode == 4'd3) && (cmd_q[11:4] == 8'd0);
  assign tbl_idx   = {opcode == 4'd2, cmd_q[3:0]};
  assign timed_out = (tmo_cnt >= TW'(SW_TIMEOUT));

  assign sw_cmd_valid   = (state == S_SW_FWD);
  assign sw_cmd_data    = cmd_q;
  assign eng_release    = (state == S_RELEASE);
  assign eng_resp_valid = eng_release && resp_flag;

  // Next-state decode and per-cycle event strobes
  always_comb begin
    next_state = state;
    do_latch   = 1'b0;
    do_perr    = 1'b0;
    do_hw      = 1'b0;
    do_sw      = 1'b0;
    do_tmo     = 1'b0;
    do_cap     = 1'b0;
    clr_tmo    = 1'b0;
    case (state)
      S_IDLE: if (eng_cmd_valid) begin
        do_latch   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (cmd_q[16]) begin
          do_perr    = 1'b1;
          next_state = S_RELEASE;
        end else if (hw_hit) begin
          next_state = S_HW_RESP;
        end else begin
          clr_tmo    = 1'b1;
          next_state = S_SW_FWD;
        end
      end
      S_HW_RESP: begin
        do_hw      = 1'b1;
        next_state = S_RELEASE;
      end
      // A handshake completing on the limit cycle takes priority over the timeout
      S_SW_FWD: begin
        if (sw_cmd_ready) begin
          do_sw      = 1'b1;
          next_state = S_SW_RESP;
        end else if (timed_out) begin
          do_tmo     = 1'b1;
          next_state = S_RELEASE;
        end
      end
      S_SW_RESP: begin
        if (sw_resp_valid) begin
          do_cap     = 1'b1;
          next_state = S_RELEASE;
        end else if (timed_out) begin
          do_tmo     = 1'b1;
          next_state = S_RELEASE;
        end
      end
      S_RELEASE: next_state = S_DRAIN;
      // Wait for the engine to drop its level so it is not accepted twice
      S_DRAIN: if (!eng_cmd_valid) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register, command latch and software timeout counter
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      state   <= S_IDLE;
      cmd_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= next_state;
      if (do_latch) cmd_q <= eng_cmd_data;
      if (clr_tmo) tmo_cnt <= '0;
      else if ((state == S_SW_FWD || state == S_SW_RESP) && !timed_out)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Response word/flag, attention pulse, reply-ready and saturating counters
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      resp_flag     <= 1'b0;
      eng_resp_data <= '0;
      attention_req <= 1'b0;
      sw_resp_ready <= 1'b0;
      hw_count      <= '0;
      sw_count      <= '0;
      perr_count    <= '0;
      tmo_count     <= '0;
    end else begin
      attention_req <= do_perr || do_tmo;
      sw_resp_ready <= (next_state == S_IDLE) || (next_state == S_SW_RESP) || (next_state == S_DRAIN);
      if (do_perr || do_tmo) resp_flag <= 1'b0;
      if (do_hw) begin
        resp_flag     <= 1'b1;
        eng_resp_data <= tbl[tbl_idx];
      end
      if (do_cap) begin
        resp_flag <= sw_resp_has_data;
        if (sw_resp_has_data) eng_resp_data <= sw_resp_data;
      end
      if (do_hw   && hw_count   != 16'hFFFF) hw_count   <= hw_count + 16'd1;
      if (do_sw   && sw_count   != 16'hFFFF) sw_count   <= sw_count + 16'd1;
      if (do_perr && perr_count != 16'hFFFF) perr_count <= perr_count + 16'd1;
      if (do_tmo  && tmo_count  != 16'hFFFF) tmo_count  <= tmo_count + 16'd1;
    end
  end

  // Status/config word tables; a same-cycle write is not visible to the read
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      for (int i = 0; i < 32; i++) tbl[i] <= '0;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Directed bench for esdi_cmd_sequencer with a short software timeout.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Software-side handshakes are driven explicitly per test case.
module tb_esdi_cmd_sequencer;

  logic        csr_aclk;
  logic        csr_aresetn;
  logic        hw_enable;
  logic        eng_cmd_valid;
  logic [16:0] eng_cmd_data;
  logic        eng_resp_valid;
  logic [15:0] eng_resp_data;
  logic        eng_release;
  logic        tbl_we;
  logic [4:0]  tbl_addr;
  logic [15:0] tbl_wdata;
  logic        sw_cmd_valid;
  logic [16:0] sw_cmd_data;
  logic        sw_cmd_ready;
  logic        sw_resp_valid;
  logic        sw_resp_has_data;
  logic [15:0] sw_resp_data;
  logic        sw_resp_ready;
  logic        attention_req;
  logic [15:0] hw_count, sw_count, perr_count, tmo_count;

  int checks = 0;
  int failures = 0;
  int rel, attn, swv;

  esdi_cmd_sequencer #(.SW_TIMEOUT(20)) dut (
    .csr_aclk(csr_aclk), .csr_aresetn(csr_aresetn), .hw_enable(hw_enable),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_data(eng_cmd_data),
    .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data), .eng_release(eng_release),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .sw_cmd_valid(sw_cmd_valid), .sw_cmd_data(sw_cmd_data), .sw_cmd_ready(sw_cmd_ready),
    .sw_resp_valid(sw_resp_valid), .sw_resp_has_data(sw_resp_has_data),
    .sw_resp_data(sw_resp_data), .sw_resp_ready(sw_resp_ready),
    .attention_req(attention_req), .hw_count(hw_count), .sw_count(sw_count),
    .perr_count(perr_count), .tmo_count(tmo_count)
  );

  initial csr_aclk = 1'b0;
  always #5 csr_aclk = ~csr_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge csr_aclk);
    #1;
  endtask

  // Advance n cycles, counting cycles with release, attention and sw_cmd_valid high
  task automatic run_cycles(input int n, output int r, output int a, output int s);
    r = 0; a = 0; s = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (eng_release)   r++;
      if (attention_req) a++;
      if (sw_cmd_valid)  s++;
    end
  endtask

  task automatic drop_cmd();
    eng_cmd_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    csr_aresetn = 1'b0; hw_enable = 1'b1; eng_cmd_valid = 1'b0; eng_cmd_data = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; sw_cmd_ready = 1'b0;
    sw_resp_valid = 1'b0; sw_resp_has_data = 1'b0; sw_resp_data = '0;
    #12;
    check("rst_release", eng_release, 0);
    check("rst_resp_valid", eng_resp_valid, 0);
    check("rst_sw_cmd_valid", sw_cmd_valid, 0);
    check("rst_sw_resp_ready", sw_resp_ready, 0);
    check("rst_attention", attention_req, 0);
    check("rst_resp_data", eng_resp_data, 0);
    check("rst_counters", {hw_count, sw_count | perr_count | tmo_count}, 0);
    @(negedge csr_aclk) csr_aresetn = 1'b1;
    step();
    check("idle_sw_resp_ready", sw_resp_ready, 1);

    // Hardware status request: table[19] = 0xBEEF, cmd 0x2003
    tbl_we = 1'b1; tbl_addr = 5'd19; tbl_wdata = 16'hBEEF;
    step();
    tbl_we = 1'b0;
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h02003;
    run_cycles(3, rel, attn, swv);
    check("hw_release_n3", eng_release, 1);
    check("hw_release_count", rel, 1);
    check("hw_resp_valid", eng_resp_valid, 1);
    check("hw_resp_data", eng_resp_data, 16'hBEEF);
    check("hw_no_sw_fwd", swv, 0);
    check("hw_count1", hw_count, 1);
    // Engine keeps its level high for 5 cycles: no second release
    run_cycles(5, rel, attn, swv);
    check("drain_single_release", rel, 0);
    drop_cmd();

    // Forward with hw disabled, reply with data
    hw_enable = 1'b0;
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h03001;
    run_cycles(2, rel, attn, swv);
    check("fwd_valid", sw_cmd_valid, 1);
    check("fwd_data", sw_cmd_data, 17'h03001);
    run_cycles(2, rel, attn, swv);
    check("fwd_held", swv, 2);
    check("fwd_data_stable", sw_cmd_data, 17'h03001);
    sw_cmd_ready = 1'b1;
    step();
    sw_cmd_ready = 1'b0;
    check("fwd_valid_drop", sw_cmd_valid, 0);
    check("resp_ready", sw_resp_ready, 1);
    check("sw_count1", sw_count, 1);
    sw_resp_valid = 1'b1; sw_resp_has_data = 1'b1; sw_resp_data = 16'h1234;
    step();
    sw_resp_valid = 1'b0;
    check("sw_release", eng_release, 1);
    check("sw_resp_valid", eng_resp_valid, 1);
    check("sw_resp_data", eng_resp_data, 16'h1234);
    drop_cmd();

    // Opcode 0 forwarded even with hw enabled; reply without data
    hw_enable = 1'b1;
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h00123;
    run_cycles(2, rel, attn, swv);
    check("fwd0_data", sw_cmd_data, 17'h00123);
    sw_cmd_ready = 1'b1;
    step();
    sw_cmd_ready = 1'b0;
    sw_resp_valid = 1'b1; sw_resp_has_data = 1'b0; sw_resp_data = 16'hDEAD;
    step();
    sw_resp_valid = 1'b0;
    check("nodata_release", eng_release, 1);
    check("nodata_resp_valid", eng_resp_valid, 0);
    check("sw_count2", sw_count, 2);
    drop_cmd();

    // Parity error
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h12003;
    run_cycles(2, rel, attn, swv);
    check("perr_release", eng_release, 1);
    check("perr_resp_valid", eng_resp_valid, 0);
    check("perr_attention", attention_req, 1);
    check("perr_no_sw", swv, 0);
    check("perr_count1", perr_count, 1);
    check("perr_hw_count", hw_count, 1);
    eng_cmd_valid = 1'b0;
    step();
    check("attention_one_cycle", attention_req, 0);
    step();

    // Timeout: no sw_cmd_ready, release on cycle 21 after SW_FWD entry
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h00005;
    run_cycles(2, rel, attn, swv);
    run_cycles(20, rel, attn, swv);
    check("tmo_no_early_release", rel, 0);
    check("tmo_valid_held", swv, 20);
    step();
    check("tmo_release", eng_release, 1);
    check("tmo_attention", attention_req, 1);
    check("tmo_resp_valid", eng_resp_valid, 0);
    check("tmo_count1", tmo_count, 1);
    drop_cmd();
    // Late reply in IDLE is consumed and dropped
    sw_resp_valid = 1'b1; sw_resp_has_data = 1'b1; sw_resp_data = 16'h7777;
    check("stray_ready", sw_resp_ready, 1);
    step();
    sw_resp_valid = 1'b0;
    run_cycles(4, rel, attn, swv);
    check("stray_no_release", rel, 0);
    check("stray_no_fwd", swv, 0);
    check("stray_sw_count", sw_count, 2);

    // Reply exactly on cycle 20 wins over the timeout
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h00006;
    run_cycles(2, rel, attn, swv);
    sw_cmd_ready = 1'b1;
    step();
    sw_cmd_ready = 1'b0;
    run_cycles(19, rel, attn, swv);
    check("edge_no_early_release", rel, 0);
    sw_resp_valid = 1'b1; sw_resp_has_data = 1'b1; sw_resp_data = 16'hA5A5;
    step();
    sw_resp_valid = 1'b0;
    check("edge_release", eng_release, 1);
    check("edge_resp_valid", eng_resp_valid, 1);
    check("edge_resp_data", eng_resp_data, 16'hA5A5);
    check("edge_no_attention", attention_req, 0);
    check("edge_tmo_count", tmo_count, 1);
    check("sw_count3", sw_count, 3);
    drop_cmd();

    // Table write in the HW_RESP cycle returns the old word
    tbl_we = 1'b1; tbl_addr = 5'd3; tbl_wdata = 16'h1111;
    step();
    tbl_we = 1'b0;
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h03003;
    run_cycles(2, rel, attn, swv);
    tbl_we = 1'b1; tbl_addr = 5'd3; tbl_wdata = 16'h2222;
    step();
    tbl_we = 1'b0;
    check("collide_release", eng_release, 1);
    check("collide_old_word", eng_resp_data, 16'h1111);
    drop_cmd();
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h03003;
    run_cycles(3, rel, attn, swv);
    check("cfg_new_word", eng_resp_data, 16'h2222);
    check("hw_count3", hw_count, 3);
    drop_cmd();

    // Opcode 3 with nonzero middle bits is forwarded; reset while in SW_RESP
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h03013;
    run_cycles(2, rel, attn, swv);
    check("mid_bits_fwd", sw_cmd_valid, 1);
    sw_cmd_ready = 1'b1;
    step();
    sw_cmd_ready = 1'b0;
    check("pre_rst_resp_ready", sw_resp_ready, 1);
    csr_aresetn = 1'b0; eng_cmd_valid = 1'b0;
    #2;
    check("midrst_release", eng_release, 0);
    check("midrst_sw_resp_ready", sw_resp_ready, 0);
    check("midrst_sw_cmd_valid", sw_cmd_valid, 0);
    check("midrst_resp_data", eng_resp_data, 0);
    check("midrst_counters", {hw_count, sw_count}, 0);
    @(negedge csr_aclk) csr_aresetn = 1'b1;
    run_cycles(4, rel, attn, swv);
    check("postrst_no_release", rel, 0);
    check("postrst_resp_ready", sw_resp_ready, 1);
    eng_cmd_valid = 1'b1; eng_cmd_data = 17'h03003;
    run_cycles(3, rel, attn, swv);
    check("postrst_release", eng_release, 1);
    check("postrst_table_zero", eng_resp_data, 0);
    drop_cmd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esdi_cmd_sequencer.md
# esdi_cmd_sequencer

Hardware command sequencer between the ESDI serial command engine and software. It takes each received 17-bit command word (16 data bits plus a parity-error flag) and answers Request Status and Request Configuration commands directly from on-chip word tables. All other commands go to software through a ready/valid handshake, with a timeout. Every command ends with exactly one release pulse back to the engine, optionally carrying a 16-bit response word.

## Interface
- `SW_TIMEOUT`, default 1_000_000: number of cycles in SW_WAIT/SW_RESP before a forwarded command is abandoned (10 ms at 100 MHz).
- `csr_aclk` in, 1: sole clock.
- `csr_aresetn` in, 1: asynchronous, active-low reset.
- `hw_enable` in, 1: 1 = answer opcodes 2/3 in hardware; 0 = forward everything.
- `eng_cmd_valid` in, 1: level; a command is pending in the engine.
- `eng_cmd_data` in, 17: [15:0] command word; [16] parity error.
- `eng_resp_valid` out, 1: response word accompanies this release.
- `eng_resp_data` out, 16: response word.
- `eng_release` out, 1: one-cycle pulse; the engine clears its pending command.
- `tbl_we` in, 1: table write strobe.
- `tbl_addr` in, 5: 0–15 config words, 16–31 status words.
- `tbl_wdata` in, 16: table write data.
- `sw_cmd_valid` out, 1 / `sw_cmd_data` out, 17 / `sw_cmd_ready` in, 1: forward to software.
- `sw_resp_valid` in, 1 / `sw_resp_has_data` in, 1 / `sw_resp_data` in, 16 / `sw_resp_ready` out, 1: software reply.
- `attention_req` out, 1: one-cycle pulse requesting ESDI attention.
- `hw_count`, `sw_count`, `perr_count`, `tmo_count` out, 16 each: saturating event counters.

## Operation
- States: IDLE, DECODE, HW_RESP, SW_FWD, SW_RESP, RELEASE, DRAIN.
- **IDLE:** `eng_cmd_valid`=1 → latch `eng_cmd_data` into `cmd_q` and go to DECODE.
- **DECODE** (one cycle):
  - parity bit 1 → RELEASE with no data; pulse `attention_req`; `perr_count`++.
  - `hw_enable`=1, opcode `cmd_q[15:12]`==2 or 3, and `cmd_q[11:4]`==0 → HW_RESP. The table index is `{opcode==2, cmd_q[3:0]}`.
  - otherwise → SW_FWD.
- **HW_RESP:** register the table word into `eng_resp_data`, set the response flag, `hw_count`++ → RELEASE.
- **SW_FWD:** assert `sw_cmd_valid` with `sw_cmd_data`=`cmd_q`. On `sw_cmd_ready` → SW_RESP; `sw_count`++.
- **SW_RESP:** `sw_resp_ready`=1. On `sw_resp_valid`, capture `sw_resp_has_data`/`sw_resp_data` → RELEASE.
- **Timeout:** a cycle counter clears on DECODE→SW_FWD. If it reaches `SW_TIMEOUT` in SW_FWD or SW_RESP → RELEASE with no data; pulse `attention_req`; `tmo_count`++.
- **RELEASE:** `eng_release`=1 for one cycle, with `eng_resp_valid`=response flag → DRAIN.
- **DRAIN:** wait for `eng_cmd_valid`=0, then → IDLE. This prevents a stale level from being re-accepted.
- **Tables:** 32×16 registers, reset to 0. A write in the same cycle as the HW_RESP read returns the old word.
- **Stray replies:** `sw_resp_ready`=1 also in IDLE and DRAIN. Replies arriving there (late, after timeout) are consumed and dropped.
- **Counters:** saturate at 0xFFFF.

## Timing
- Reset (async, any state): state=IDLE; `eng_release`, `eng_resp_valid`, `sw_cmd_valid`, `sw_resp_ready`, `attention_req`=0; `eng_resp_data`=0; counters and tables =0. Reset mid-command does not release it.
- Hardware path: `eng_cmd_valid` seen at cycle N → DECODE at N+1 → HW_RESP at N+2 → `eng_release`/`eng_resp_valid` high at N+3.
- Software path: release comes one cycle after the `sw_resp_valid` handshake. `sw_cmd_valid` stays asserted, with data stable, until `sw_cmd_ready`.
- `attention_req` pulses in the same cycle the parity or timeout RELEASE is entered.
- Timeout: release exactly `SW_TIMEOUT`+1 cycles after SW_FWD entry if no handshake completes. A handshake in the same cycle the count hits the limit wins; no timeout is taken.
- `eng_resp_data` holds its last value between releases.

## Test plan
- Table[19]=0xBEEF, `hw_enable`=1, cmd 0x2003 → release at cycle N+3 with resp 0xBEEF; `hw_count`=1; no `sw_cmd_valid`.
- `hw_enable`=0, cmd 0x3001 → `sw_cmd_valid` with data 0x03001. Reply has_data=1, 0x1234 → release with resp 0x1234; `sw_count`=1.
- Cmd 0x0123 forwarded; reply has_data=0 → release with `eng_resp_valid`=0.
- Cmd with bit 16 set → release with no data plus `attention_req` pulse; `perr_count`=1; software untouched.
- `SW_TIMEOUT`=20, no `sw_cmd_ready` → release at cycle 21 after SW_FWD entry, attention pulse, `tmo_count`=1. A later `sw_resp_valid` is dropped. Repeat with the reply on exactly cycle 20 → normal reply, no timeout.
- `eng_cmd_valid` held high 5 cycles after release → single release only. Assert reset during SW_RESP → IDLE, no release, outputs zeroed.
